// File: rtl/noc_reader.sv
// noc_reader
//   Sink endpoint for one router output port. Incoming flits are buffered in a
//   small FIFO whose full/almost_full go back to the router as backpressure.
//   Each popped flit is checked for destination and per-source sequence order.
//   Error flags pulse alongside rx_valid. Traffic and error counters run from reset.
//
//   Flit layout: {dest[15:14], src[13:12], seq[11:0]}
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_write_in     flit strobe from router writeOut
//   i_data_in      flit from router dataOut
//   i_stall        1 = hold the FIFO (no pop this cycle)
//   o_full         FIFO full (router readFull)
//   o_almost_full  free entries <= AF_LEVEL (router read_almostfull)
//   o_rx_valid     one-cycle pulse, o_rx_data holds the popped flit
//   o_rx_data      last popped flit
//   o_err_dest     pulse with rx_valid: dest != LOCAL_ID
//   o_err_seq      pulse with rx_valid: seq != expected seq for that source
//   o_overflow     sticky: a write arrived while full
//   o_pkt_count    flits popped since reset (wrapping)
//   o_err_count    flits with any error (saturating)
`timescale 1ns/1ps
module noc_reader #(
  parameter int         WIDTH    = 16,
  parameter int         DEPTH    = 8,
  parameter logic [1:0] LOCAL_ID = 2'b00,
  parameter int         AF_LEVEL = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_write_in,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_stall,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_rx_valid,
  output logic [WIDTH-1:0] o_rx_data,
  output logic             o_err_dest,
  output logic             o_err_seq,
  output logic             o_overflow,
  output logic [15:0]      o_pkt_count,
  output logic [15:0]      o_err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_cnt;

  logic [11:0]      r_expected [4];
  logic             r_rx_valid;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_err_dest;
  logic             r_err_seq;
  logic             r_overflow;
  logic [15:0]      r_pkt_count;
  logic [15:0]      r_err_count;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_flit;
  logic [1:0]       w_src;
  logic             w_bad_dest;
  logic             w_bad_seq;

  assign w_full = (r_cnt == CW'(DEPTH));
  // Push is judged against the registered count only, so a same-cycle pop
  // never frees room for a write that arrives while full.
  assign w_push = i_write_in && !w_full;
  assign w_pop  = !i_stall && (r_cnt != '0);

  assign w_flit     = r_mem[r_rd_ptr];
  assign w_src      = w_flit[13:12];
  assign w_bad_dest = (w_flit[15:14] != LOCAL_ID);
  assign w_bad_seq  = (w_flit[11:0] != r_expected[w_src]);

  // Storage carries no reset: stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_err_dest  <= 1'b0;
      r_err_seq   <= 1'b0;
      r_overflow  <= 1'b0;
      r_pkt_count <= '0;
      r_err_count <= '0;
      for (int i = 0; i < 4; i++) begin
        r_expected[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (i_write_in && w_full) begin
        r_overflow <= 1'b1;
      end

      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase

      r_rx_valid <= w_pop;
      r_err_dest <= w_pop && w_bad_dest;
      r_err_seq  <= w_pop && w_bad_seq;

      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_rx_data   <= w_flit;
        // Always track the received seq so one gap produces a single error.
        r_expected[w_src] <= w_flit[11:0] + 12'd1;
        r_pkt_count <= r_pkt_count + 16'd1;
        if ((w_bad_dest || w_bad_seq) && (r_err_count != 16'hFFFF)) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  assign o_full        = w_full;
  assign o_almost_full = ((DEPTH - int'(r_cnt)) <= AF_LEVEL);
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_data     = r_rx_data;
  assign o_err_dest    = r_err_dest;
  assign o_err_seq     = r_err_seq;
  assign o_overflow    = r_overflow;
  assign o_pkt_count   = r_pkt_count;
  assign o_err_count   = r_err_count;

endmodule

// File: tb/tb_noc_reader.sv
`timescale 1ns/1ps
module tb_noc_reader;

  localparam int         WIDTH    = 16;
  localparam int         DEPTH    = 8;
  localparam logic [1:0] LOCAL_ID = 2'b00;
  localparam int         AF_LEVEL = 2;

  logic             i_clk = 1'b0;
  logic             i_reset = 1'b0;
  logic             i_write_in = 1'b0;
  logic [WIDTH-1:0] i_data_in = '0;
  logic             i_stall = 1'b0;
  logic             o_full;
  logic             o_almost_full;
  logic             o_rx_valid;
  logic [WIDTH-1:0] o_rx_data;
  logic             o_err_dest;
  logic             o_err_seq;
  logic             o_overflow;
  logic [15:0]      o_pkt_count;
  logic [15:0]      o_err_count;

  noc_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LOCAL_ID(LOCAL_ID), .AF_LEVEL(AF_LEVEL)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_write_in(i_write_in),
    .i_data_in(i_data_in), .i_stall(i_stall), .o_full(o_full),
    .o_almost_full(o_almost_full), .o_rx_valid(o_rx_valid),
    .o_rx_data(o_rx_data), .o_err_dest(o_err_dest), .o_err_seq(o_err_seq),
    .o_overflow(o_overflow), .o_pkt_count(o_pkt_count),
    .o_err_count(o_err_count)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h", tag, got, exp);
  endtask

  // Reference model: a queue of flits plus the per-source sequence table.
  logic [15:0] m_q[$];
  logic [11:0] m_exp [4];
  logic        m_rx_valid, m_err_dest, m_err_seq, m_overflow;
  logic [15:0] m_rx_data, m_pkt, m_errc;
  logic [11:0] send_seq [4];

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 4; i++) m_exp[i] = 12'd0;
    m_rx_valid = 0; m_err_dest = 0; m_err_seq = 0; m_overflow = 0;
    m_rx_data = 0; m_pkt = 0; m_errc = 0;
  endtask

  task automatic check_all(input string ctx);
    int sz;
    sz = m_q.size();
    check({ctx, ".rx_valid"},  32'(o_rx_valid),    32'(m_rx_valid));
    check({ctx, ".rx_data"},   32'(o_rx_data),     32'(m_rx_data));
    check({ctx, ".err_dest"},  32'(o_err_dest),    32'(m_err_dest));
    check({ctx, ".err_seq"},   32'(o_err_seq),     32'(m_err_seq));
    check({ctx, ".overflow"},  32'(o_overflow),    32'(m_overflow));
    check({ctx, ".pkt_count"}, 32'(o_pkt_count),   32'(m_pkt));
    check({ctx, ".err_count"}, 32'(o_err_count),   32'(m_errc));
    check({ctx, ".full"},      32'(o_full),        32'(sz == DEPTH));
    check({ctx, ".almost"},    32'(o_almost_full), 32'((DEPTH - sz) <= AF_LEVEL));
  endtask

  // One clock cycle: drive inputs, advance the model across the edge, compare.
  task automatic step(input logic w, input logic [15:0] d, input logic s, input string ctx);
    logic        was_full;
    logic [15:0] f;
    i_write_in = w; i_data_in = d; i_stall = s;
    @(posedge i_clk);
    was_full   = (m_q.size() == DEPTH);
    m_rx_valid = 0; m_err_dest = 0; m_err_seq = 0;
    if (!s && m_q.size() != 0) begin
      f = m_q.pop_front();
      m_rx_valid = 1;
      m_rx_data  = f;
      m_err_dest = (f[15:14] != LOCAL_ID);
      m_err_seq  = (f[11:0] != m_exp[f[13:12]]);
      m_exp[f[13:12]] = f[11:0] + 12'd1;
      m_pkt = m_pkt + 16'd1;
      if ((m_err_dest || m_err_seq) && m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
    end
    if (w) begin
      if (was_full) m_overflow = 1;
      else m_q.push_back(d);
    end
    #1;
    if (m_rx_valid)
      $display("%s rx flit=%h err_dest=%0b err_seq=%0b pkt=%0d errs=%0d",
               ctx, o_rx_data, o_err_dest, o_err_seq, o_pkt_count, o_err_count);
    check_all(ctx);
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset(input string ctx);
    i_write_in = 0; i_stall = 0;
    #2;
    i_reset = 1;
    model_reset();
    #1;
    check_all({ctx, ".async"});
    @(posedge i_clk);
    #1;
    i_reset = 0;
    check_all({ctx, ".held"});
  endtask

  function automatic logic [15:0] flit(input logic [1:0] dst, input logic [1:0] src,
                                       input logic [11:0] seq);
    return {dst, src, seq};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) send_seq[i] = 12'd0;
    model_reset();
    @(posedge i_clk); #1;
    do_reset("rst0");

    // Back-to-back flits, no stall.
    for (int k = 0; k < 3; k++) step(1, flit(2'b00, 2'b01, 12'(k)), 0, "b2b");
    for (int k = 0; k < 2; k++) step(0, 16'h0, 0, "b2b_drain");
    check("b2b.pkt3", 32'(o_pkt_count), 32'd3);

    // Fill under stall, overflow on the ninth write, then drain.
    do_reset("rst1");
    for (int k = 0; k < 8; k++) begin
      step(1, flit(2'b00, 2'b00, 12'(k)), 1, "fill");
      if (k == 5) check("fill.af_after6", 32'(o_almost_full), 32'd1);
      if (k == 6) check("fill.notfull7", 32'(o_full), 32'd0);
    end
    check("fill.full8", 32'(o_full), 32'd1);
    step(1, flit(2'b00, 2'b00, 12'd99), 1, "ovf");
    check("ovf.sticky", 32'(o_overflow), 32'd1);
    for (int k = 0; k < 9; k++) step(0, 16'h0, 0, "drain");
    check("drain.fullclr", 32'(o_full), 32'd0);

    // Wrong destination.
    do_reset("rst2");
    step(1, flit(2'b01, 2'b00, 12'd0), 0, "dest");
    step(0, 16'h0, 0, "dest");
    check("dest.errc", 32'(o_err_count), 32'd1);

    // Sequence gap with resync, then 4095 -> 0 wrap.
    do_reset("rst3");
    step(1, flit(2'b00, 2'b10, 12'd0), 0, "seq");
    step(1, flit(2'b00, 2'b10, 12'd1), 0, "seq");
    step(1, flit(2'b00, 2'b10, 12'd3), 0, "seq");
    step(1, flit(2'b00, 2'b10, 12'd4), 0, "seq");
    step(1, flit(2'b00, 2'b11, 12'd4095), 0, "seq");
    step(1, flit(2'b00, 2'b11, 12'd0), 0, "seq");
    step(0, 16'h0, 0, "seq");
    step(0, 16'h0, 0, "seq");
    check("seq.errc", 32'(o_err_count), 32'd2);

    // Reset with flits buffered: nothing may emerge afterwards.
    for (int k = 0; k < 5; k++) step(1, flit(2'b00, 2'b01, 12'(k)), 1, "buf");
    do_reset("rst4");
    for (int k = 0; k < 3; k++) step(0, 16'h0, 0, "postrst");

    // Randomised traffic with occasional sequence gaps and wrong destinations.
    do_reset("rst5");
    for (int i = 0; i < 4; i++) send_seq[i] = 12'd0;
    for (int c = 0; c < 600; c++) begin
      logic        w, s;
      logic [1:0]  src, dst;
      logic [11:0] seq;
      w   = ($urandom_range(0, 99) < 65);
      s   = ($urandom_range(0, 99) < 35);
      src = 2'($urandom_range(0, 3));
      dst = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : LOCAL_ID;
      seq = send_seq[src];
      if ($urandom_range(0, 19) == 0) seq = seq + 12'($urandom_range(1, 5));
      if (w) send_seq[src] = seq + 12'd1;
      if (c == 300) begin
        do_reset("rst_rand");
        for (int i = 0; i < 4; i++) send_seq[i] = 12'd0;
      end else begin
        step(w, flit(dst, src, seq), s, "rand");
      end
    end
    for (int k = 0; k < DEPTH + 2; k++) step(0, 16'h0, 0, "final");
    check("final.empty_almost", 32'(o_almost_full), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
